// File: rtl/pet2001_char_shifter_if.sv
// rtl/pet2001_char_shifter_if.sv - CRTC-compatible video timing bundle from timing source to char shifter
// The timing source drives every field; the character shifter only samples them on ce_1m.
interface pet2001_char_shifter_if;
  logic        vid_de;
  logic [13:0] vid_ma;
  logic [4:0]  vid_ra;
  logic        vid_hblank;
  logic        vid_vblank;
  logic        vid_hsync;
  logic        vid_vsync;
  logic        vid_cursor;

  modport master (
    output vid_de, vid_ma, vid_ra, vid_hblank, vid_vblank,
    output vid_hsync, vid_vsync, vid_cursor
  );

  modport slave (
    input vid_de, vid_ma, vid_ra, vid_hblank, vid_vblank,
    input vid_hsync, vid_vsync, vid_cursor
  );
endinterface

// File: rtl/pet2001_char_shifter.sv
// rtl/pet2001_char_shifter.sv - PET 2001 character fetch pipeline and pixel shifter
// Three ce_1m stages (vram fetch, char ROM fetch, shifter load); sync/blank ride along to stay pixel-aligned.
module pet2001_char_shifter #(
  parameter int VADDR_W  = 11,
  parameter int PIPE_DLY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce_1m,
  input  logic                   ce_8m,
  pet2001_char_shifter_if.slave  vid,
  input  logic                   video_blank,
  input  logic                   video_gfx,
  input  logic [7:0]             vram_data,
  input  logic [7:0]             crom_data,
  output logic [VADDR_W-1:0]     vram_addr,
  output logic [10:0]            crom_addr,
  output logic                   pix,
  output logic                   pix_de,
  output logic                   pix_hblank,
  output logic                   pix_vblank,
  output logic                   pix_hsync,
  output logic                   pix_vsync,
  output logic                   ce_err
);

  logic [VADDR_W-1:0]  r_vram_addr;
  logic [10:0]         r_crom_addr;
  logic [PIPE_DLY-1:0] r_vld;

  logic       r_de_s1, r_cur_s1, r_hb_s1, r_vb_s1, r_hs_s1, r_vs_s1;
  logic [2:0] r_ra_s1;
  logic       r_de_s2, r_inv_s2, r_hb_s2, r_vb_s2, r_hs_s2, r_vs_s2;

  logic       r_pix_de, r_pix_hb, r_pix_vb, r_pix_hs, r_pix_vs;
  logic [7:0] r_sr;

  logic [3:0] r_cnt;
  logic       r_win_open;
  logic       r_ce_err;

  logic       w_load_ok;
  logic [7:0] w_glyph;
  logic       w_unused;

  assign w_load_ok = r_de_s2 && r_vld[PIPE_DLY-1] && !video_blank;
  assign w_glyph   = crom_data ^ {8{r_inv_s2}};
  assign w_unused  = ^{vid.vid_ma[13:VADDR_W], vid.vid_ra[4:3]};

  // Fetch pipeline: S1 samples the timing source, S2 forms the ROM address, S3 emits aligned syncs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vram_addr <= '0;
      r_crom_addr <= '0;
      r_vld       <= '0;
      r_de_s1     <= 1'b0;
      r_ra_s1     <= 3'd0;
      r_cur_s1    <= 1'b0;
      r_hb_s1     <= 1'b1;
      r_vb_s1     <= 1'b1;
      r_hs_s1     <= 1'b0;
      r_vs_s1     <= 1'b0;
      r_de_s2     <= 1'b0;
      r_inv_s2    <= 1'b0;
      r_hb_s2     <= 1'b1;
      r_vb_s2     <= 1'b1;
      r_hs_s2     <= 1'b0;
      r_vs_s2     <= 1'b0;
      r_pix_de    <= 1'b0;
      r_pix_hb    <= 1'b1;
      r_pix_vb    <= 1'b1;
      r_pix_hs    <= 1'b0;
      r_pix_vs    <= 1'b0;
    end else if (ce_1m) begin
      r_vram_addr <= vid.vid_ma[VADDR_W-1:0];
      r_vld       <= {r_vld[PIPE_DLY-2:0], 1'b1};
      r_de_s1     <= vid.vid_de;
      r_ra_s1     <= vid.vid_ra[2:0];
      r_cur_s1    <= vid.vid_cursor;
      r_hb_s1     <= vid.vid_hblank;
      r_vb_s1     <= vid.vid_vblank;
      r_hs_s1     <= vid.vid_hsync;
      r_vs_s1     <= vid.vid_vsync;

      r_crom_addr <= {video_gfx, vram_data[6:0], r_ra_s1};
      r_inv_s2    <= vram_data[7] ^ r_cur_s1;
      r_de_s2     <= r_de_s1 && r_vld[0];
      r_hb_s2     <= r_hb_s1;
      r_vb_s2     <= r_vb_s1;
      r_hs_s2     <= r_hs_s1;
      r_vs_s2     <= r_vs_s1;

      r_pix_de    <= r_de_s2;
      r_pix_hb    <= r_hb_s2;
      r_pix_vb    <= r_vb_s2;
      r_pix_hs    <= r_hs_s2;
      r_pix_vs    <= r_vs_s2;
    end
  end

  // Load on the slot edge takes priority over the coincident pixel shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr <= 8'h00;
    end else if (ce_1m) begin
      r_sr <= w_load_ok ? w_glyph : 8'h00;
    end else if (ce_8m) begin
      r_sr <= {r_sr[6:0], 1'b0};
    end
  end

  // The ce_8m that coincides with ce_1m opens the next window, so a healthy window holds exactly 8.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= 4'd0;
      r_win_open <= 1'b0;
      r_ce_err   <= 1'b0;
    end else if (ce_1m) begin
      if (r_win_open && (r_cnt != 4'd8)) begin
        r_ce_err <= 1'b1;
      end
      r_cnt      <= {3'd0, ce_8m};
      r_win_open <= 1'b1;
    end else if (ce_8m && (r_cnt != 4'hF)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign vram_addr  = r_vram_addr;
  assign crom_addr  = r_crom_addr;
  assign pix        = r_sr[7];
  assign pix_de     = r_pix_de;
  assign pix_hblank = r_pix_hb;
  assign pix_vblank = r_pix_vb;
  assign pix_hsync  = r_pix_hs;
  assign pix_vsync  = r_pix_vs;
  assign ce_err     = r_ce_err;

endmodule

// File: tb/tb_pet2001_char_shifter.sv
// tb/tb_pet2001_char_shifter.sv - directed bench for pet2001_char_shifter
// Each slot is 16 clk: ce_8m every 2nd clk, ce_1m on the first of them; RAM/ROM are combinational arrays.
module tb_pet2001_char_shifter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_1m, ce_8m;
  logic        video_blank, video_gfx;
  logic [7:0]  vram_data, crom_data;
  logic [10:0] vram_addr;
  logic [10:0] crom_addr;
  logic        pix, pix_de, pix_hblank, pix_vblank, pix_hsync, pix_vsync, ce_err;

  logic [7:0]  vram [0:2047];
  logic [7:0]  crom [0:2047];
  logic [7:0]  bits;
  logic [7:0]  cell_bits;
  logic [10:0] cell_cra;
  int          n_checks = 0;
  int          n_errors = 0;

  pet2001_char_shifter_if vif ();

  pet2001_char_shifter #(.VADDR_W(11), .PIPE_DLY(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_1m       (ce_1m),
    .ce_8m       (ce_8m),
    .vid         (vif),
    .video_blank (video_blank),
    .video_gfx   (video_gfx),
    .vram_data   (vram_data),
    .crom_data   (crom_data),
    .vram_addr   (vram_addr),
    .crom_addr   (crom_addr),
    .pix         (pix),
    .pix_de      (pix_de),
    .pix_hblank  (pix_hblank),
    .pix_vblank  (pix_vblank),
    .pix_hsync   (pix_hsync),
    .pix_vsync   (pix_vsync),
    .ce_err      (ce_err)
  );

  always #5 clk = ~clk;

  assign vram_data = vram[vram_addr];
  assign crom_data = crom[crom_addr];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One character slot; pixel i is sampled on the falling edge after the i-th shifter edge.
  task automatic slot(input bit drop);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 1) bits[7 - k/2] = pix;
      ce_1m = (k == 0);
      ce_8m = (k % 2 == 0) && !(drop && k == 6);
    end
  endtask

  task automatic run_cell(input logic [13:0] ma, input logic [4:0] ra, input logic cur,
                          output logic [10:0] cra, output logic [7:0] px);
    vif.vid_de = 1'b1; vif.vid_ma = ma; vif.vid_ra = ra; vif.vid_cursor = cur;
    slot(1'b0);
    chk("vram_addr", {5'd0, vram_addr}, {5'd0, ma[10:0]});
    vif.vid_de = 1'b0; vif.vid_ma = 14'h3FF; vif.vid_cursor = 1'b0;
    slot(1'b0);
    cra = crom_addr;
    slot(1'b0);
    px = bits;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      vram[i] = 8'h00;
      crom[i] = 8'h00;
    end
    vram[0] = 8'h01; vram[1] = 8'h81; vram[2] = 8'h02;
    crom[11'h00B] = 8'hA5; crom[11'h013] = 8'hFF; crom[11'h40B] = 8'h3C;

    reset_n = 1'b0; ce_1m = 1'b0; ce_8m = 1'b0;
    video_blank = 1'b0; video_gfx = 1'b0;
    vif.vid_de = 1'b0; vif.vid_ma = 14'h3FF; vif.vid_ra = 5'd0;
    vif.vid_hblank = 1'b0; vif.vid_vblank = 1'b0;
    vif.vid_hsync = 1'b0; vif.vid_vsync = 1'b0; vif.vid_cursor = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix", {15'd0, pix}, 16'd0);
    chk("rst_hblank", {15'd0, pix_hblank}, 16'd1);
    chk("rst_vblank", {15'd0, pix_vblank}, 16'd1);
    chk("rst_ce_err", {15'd0, ce_err}, 16'd0);
    chk("rst_crom_addr", {5'd0, crom_addr}, 16'd0);
    reset_n = 1'b1;

    // T2 basic glyph
    run_cell(14'h0000, 5'd3, 1'b0, cell_cra, cell_bits);
    chk("t2_crom_addr", {5'd0, cell_cra}, 16'h000B);
    chk("t2_pixels", {8'd0, cell_bits}, 16'h00A5);

    // T3 reverse video and cursor
    run_cell(14'h0001, 5'd3, 1'b0, cell_cra, cell_bits);
    chk("t3_crom_addr", {5'd0, cell_cra}, 16'h000B);
    chk("t3_reverse", {8'd0, cell_bits}, 16'h005A);
    run_cell(14'h0001, 5'd3, 1'b1, cell_cra, cell_bits);
    chk("t3_cursor", {8'd0, cell_bits}, 16'h00A5);

    // T4 blank and graphics set
    video_blank = 1'b1;
    run_cell(14'h0002, 5'd3, 1'b0, cell_cra, cell_bits);
    chk("t4_blank", {8'd0, cell_bits}, 16'h0000);
    video_blank = 1'b0;
    run_cell(14'h0002, 5'd3, 1'b0, cell_cra, cell_bits);
    chk("t4_noblank", {8'd0, cell_bits}, 16'h00FF);
    video_gfx = 1'b1;
    run_cell(14'h0000, 5'd3, 1'b0, cell_cra, cell_bits);
    chk("t4_gfx_addr", {5'd0, cell_cra}, 16'h040B);
    chk("t4_gfx_pixels", {8'd0, cell_bits}, 16'h003C);
    video_gfx = 1'b0;

    // ma wraps modulo 2^11
    run_cell(14'h0800, 5'd3, 1'b0, cell_cra, cell_bits);
    chk("wrap_crom_addr", {5'd0, cell_cra}, 16'h000B);
    chk("wrap_pixels", {8'd0, cell_bits}, 16'h00A5);

    // T5 sync/blank/de alignment, packed {de,hblank,vblank,hsync,vsync}
    vif.vid_hblank = 1'b1; vif.vid_vblank = 1'b1;
    repeat (3) slot(1'b0);
    chk("t5_idle", {11'd0, pix_de, pix_hblank, pix_vblank, pix_hsync, pix_vsync}, 16'b01100);
    vif.vid_de = 1'b1; vif.vid_hblank = 1'b0; vif.vid_vblank = 1'b0;
    vif.vid_hsync = 1'b1; vif.vid_vsync = 1'b1;
    slot(1'b0);
    chk("t5_slot0", {11'd0, pix_de, pix_hblank, pix_vblank, pix_hsync, pix_vsync}, 16'b01100);
    slot(1'b0);
    chk("t5_slot1", {11'd0, pix_de, pix_hblank, pix_vblank, pix_hsync, pix_vsync}, 16'b01100);
    slot(1'b0);
    chk("t5_slot2", {11'd0, pix_de, pix_hblank, pix_vblank, pix_hsync, pix_vsync}, 16'b10011);
    vif.vid_de = 1'b0; vif.vid_hsync = 1'b0; vif.vid_vsync = 1'b0;
    repeat (2) slot(1'b0);

    // T6 missing ce_8m pulse
    chk("t6_clean", {15'd0, ce_err}, 16'd0);
    slot(1'b1);
    chk("t6_before_close", {15'd0, ce_err}, 16'd0);
    slot(1'b0);
    chk("t6_set", {15'd0, ce_err}, 16'd1);
    repeat (2) slot(1'b0);
    chk("t6_sticky", {15'd0, ce_err}, 16'd1);

    // T1 async reset mid-line with a lit shifter
    vif.vid_de = 1'b1; vif.vid_ma = 14'h0002; vif.vid_ra = 5'd3;
    slot(1'b0);
    vif.vid_de = 1'b0; vif.vid_ma = 14'h3FF;
    slot(1'b0);
    @(negedge clk); ce_1m = 1'b1; ce_8m = 1'b1;
    @(negedge clk); ce_1m = 1'b0; ce_8m = 1'b0;
    chk("t1_pre_pix", {15'd0, pix}, 16'd1);
    chk("t1_pre_hblank", {15'd0, pix_hblank}, 16'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_pix", {15'd0, pix}, 16'd0);
    chk("t1_hblank", {15'd0, pix_hblank}, 16'd1);
    chk("t1_vblank", {15'd0, pix_vblank}, 16'd1);
    chk("t1_ce_err", {15'd0, ce_err}, 16'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
